// File: rtl/heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// heartbeat_monitor
//
// Watches a heartbeat square wave from a remote board or FPGA and decides
// whether that source is alive. Both edges of the heartbeat count. The time
// between consecutive edges is measured in prescaled ticks. A run of
// in-range intervals locks the monitor. It reports period violations while
// locked, and loss of heartbeat when no edge arrives for too long.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   hb_in      in   asynchronous heartbeat input (both edges are events)
//   clr_err    in   synchronous clear of err_sticky (a new error wins)
//   alive      out  high while in LOCKED
//   lost       out  high while in LOST
//   period     out  last measured edge-to-edge interval, in ticks
//   edge_count out  number of detected edges, wraps 0xFFFF -> 0
//   period_err out  one-cycle pulse on an out-of-range interval while LOCKED
//   err_sticky out  set by period_err or by entering LOST
//   state      out  00 SEARCH, 01 ACQUIRE, 10 LOCKED, 11 LOST
// -----------------------------------------------------------------------------
module heartbeat_monitor #(
  parameter int PRESCALE_W    = 16,
  parameter int MIN_TICKS     = 96,
  parameter int MAX_TICKS     = 160,
  parameter int TIMEOUT_TICKS = 256,
  parameter int LOCK_COUNT    = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hb_in,
  input  logic        clr_err,
  output logic        alive,
  output logic        lost,
  output logic [15:0] period,
  output logic [15:0] edge_count,
  output logic        period_err,
  output logic        err_sticky,
  output logic [1:0]  state
);

  // Monitor states. The encoding is visible on the state port.
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10,
    ST_LOST    = 2'b11
  } state_t;

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [15:0]       MIN_V     = 16'(MIN_TICKS);
  localparam logic [15:0]       MAX_V     = 16'(MAX_TICKS);
  localparam logic [15:0]       TIMEOUT_V = 16'(TIMEOUT_TICKS);
  // Value of the good counter just before the interval that completes a lock.
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_COUNT - 1);

  // ---------------------------------------------------------------------------
  // Tick prescaler. It is free running and never reset by heartbeat activity.
  // tick is a clock enable, not a derived clock.
  // ---------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] presc_reg;
  logic                  tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign tick = &presc_reg;

  // ---------------------------------------------------------------------------
  // Input synchroniser followed by a delayed copy for edge detection.
  // The chain is reset too, so no stale level survives a reset. Otherwise a
  // stale level could fake an edge after reset is released.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hb_dly_reg;
  logic                   hb_edge;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sync_reg[gi] <= 1'b0;
          end else begin
            sync_reg[gi] <= hb_in;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sync_reg[gi] <= 1'b0;
          end else begin
            sync_reg[gi] <= sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_dly_reg <= 1'b0;
    end else begin
      hb_dly_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Both polarities count as an event.
  assign hb_edge = sync_reg[SYNC_STAGES-1] ^ hb_dly_reg;

  // ---------------------------------------------------------------------------
  // Interval counter, measured period and edge counter.
  // The counter saturates at the timeout value. While saturated it keeps
  // asserting timeout, and it holds the saturated value for the next edge.
  // An edge in a tick cycle clears the counter, so that tick is lost.
  // ---------------------------------------------------------------------------
  logic [15:0] cnt_reg;
  logic [15:0] period_reg;
  logic [15:0] edge_count_reg;
  logic        timeout;
  logic        in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      period_reg     <= '0;
      edge_count_reg <= '0;
    end else begin
      if (hb_edge) begin
        cnt_reg        <= '0;
        period_reg     <= cnt_reg;
        edge_count_reg <= edge_count_reg + 1'b1;
      end else if (tick && (cnt_reg != TIMEOUT_V)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign timeout  = (cnt_reg == TIMEOUT_V) && !hb_edge;
  assign in_range = (cnt_reg >= MIN_V) && (cnt_reg <= MAX_V);

  // ---------------------------------------------------------------------------
  // Lock state machine.
  // ---------------------------------------------------------------------------
  state_t            state_reg;
  state_t            state_next;
  logic [GOOD_W-1:0] good_reg;
  logic [GOOD_W-1:0] good_next;
  logic              perr_next;
  logic              err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_SEARCH;
      good_reg  <= '0;
    end else begin
      state_reg <= state_next;
      good_reg  <= good_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    perr_next  = 1'b0;
    case (state_reg)
      ST_SEARCH: begin
        // The first interval runs from reset or an unknown point in time,
        // so it only starts acquisition and is not judged.
        if (hb_edge) begin
          state_next = ST_ACQUIRE;
          good_next  = '0;
        end else if (timeout) begin
          state_next = ST_LOST;
        end
      end
      ST_ACQUIRE: begin
        if (hb_edge) begin
          if (in_range) begin
            good_next = good_reg + 1'b1;
            if (good_reg == LOCK_LAST) begin
              state_next = ST_LOCKED;
            end
          end else begin
            good_next = '0;
          end
        end else if (timeout) begin
          state_next = ST_LOST;
        end
      end
      ST_LOCKED: begin
        if (hb_edge) begin
          if (!in_range) begin
            perr_next  = 1'b1;
            state_next = ST_ACQUIRE;
            good_next  = '0;
          end
        end else if (timeout) begin
          state_next = ST_LOST;
        end
      end
      default: begin
        // LOST: the counter is saturated, so this interval means nothing.
        // It only restarts acquisition.
        if (hb_edge) begin
          state_next = ST_ACQUIRE;
          good_next  = '0;
        end
      end
    endcase
  end

  // Entering LOST from any other state counts as an error, as does a
  // period violation.
  assign err_set = perr_next || ((state_next == ST_LOST) && (state_reg != ST_LOST));

  // ---------------------------------------------------------------------------
  // Registered status outputs. They decode the next state, so they move in
  // the same cycle as the state register.
  // ---------------------------------------------------------------------------
  logic alive_reg;
  logic lost_reg;
  logic period_err_reg;
  logic err_sticky_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_reg      <= 1'b0;
      lost_reg       <= 1'b0;
      period_err_reg <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      alive_reg      <= (state_next == ST_LOCKED);
      lost_reg       <= (state_next == ST_LOST);
      period_err_reg <= perr_next;
      // A new error beats a clear in the same cycle.
      if (err_set) begin
        err_sticky_reg <= 1'b1;
      end else if (clr_err) begin
        err_sticky_reg <= 1'b0;
      end
    end
  end

  assign alive      = alive_reg;
  assign lost       = lost_reg;
  assign period     = period_reg;
  assign edge_count = edge_count_reg;
  assign period_err = period_err_reg;
  assign err_sticky = err_sticky_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// tb_heartbeat_monitor
//
// Directed and randomised heartbeat gaps are applied to heartbeat_monitor
// with a 4-clock tick. The reference model works on whole events:
// - the number of ticks between two edge cycles comes from integer division
//   of absolute cycle numbers;
// - the lock rules are applied per edge;
// - the loss time is predicted arithmetically from the last edge.
// -----------------------------------------------------------------------------
module tb_heartbeat_monitor;

  localparam int PW    = 2;
  localparam int P     = 4;        // clocks per tick
  localparam int MINT  = 96;
  localparam int MAXT  = 160;
  localparam int TOUT  = 256;
  localparam int LOCKN = 4;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hb_in = 1'b0;
  logic        clr_err = 1'b0;
  logic        alive;
  logic        lost;
  logic [15:0] period;
  logic [15:0] edge_count;
  logic        period_err;
  logic        err_sticky;
  logic [1:0]  state;

  heartbeat_monitor #(
    .PRESCALE_W   (PW),
    .MIN_TICKS    (MINT),
    .MAX_TICKS    (MAXT),
    .TIMEOUT_TICKS(TOUT),
    .LOCK_COUNT   (LOCKN),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hb_in     (hb_in),
    .clr_err   (clr_err),
    .alive     (alive),
    .lost      (lost),
    .period    (period),
    .edge_count(edge_count),
    .period_err(period_err),
    .err_sticky(err_sticky),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Cycle number since reset release. Cycle 0 runs from the release to the
  // first rising edge.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int          m_state;
  int          m_good;
  int          m_period;
  logic [15:0] m_count;
  bit          m_perr;
  bit          m_sticky;
  int          prev_e;   // cycle of the last edge seen by the design, -1 = reset
  int          last_d;   // cycle of the last hb_in toggle

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ticks_before(input int x);
    return x / P;        // tick cycles c < x satisfy c mod P == P-1
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},      16'(state),      16'(m_state));
    check({tag, ".alive"},      16'(alive),      16'(m_state == 2));
    check({tag, ".lost"},       16'(lost),       16'(m_state == 3));
    check({tag, ".period"},     period,          16'(m_period));
    check({tag, ".edge_count"}, edge_count,      m_count);
    check({tag, ".period_err"}, 16'(period_err), 16'(m_perr));
    check({tag, ".err_sticky"}, 16'(err_sticky), 16'(m_sticky));
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_period = 0; m_count = 16'h0;
    m_perr = 1'b0; m_sticky = 1'b0; prev_e = -1; last_d = 0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Apply one edge seen by the design at cycle e to the model.
  task automatic model_edge(input int e, input bit clr);
    int iv;
    bit inr;
    bit setb;
    iv = ticks_before(e) - ticks_before(prev_e + 1);
    if (iv > TOUT) iv = TOUT;
    inr  = (iv >= MINT) && (iv <= MAXT);
    setb = 1'b0;
    case (m_state)
      0: begin m_state = 1; m_good = 0; end
      1: begin
        if (inr) begin
          m_good++;
          if (m_good == LOCKN) m_state = 2;
        end else begin
          m_good = 0;
        end
      end
      2: if (!inr) begin m_perr = 1'b1; setb = 1'b1; m_state = 1; m_good = 0; end
      default: begin m_state = 1; m_good = 0; end
    endcase
    m_period = iv;
    m_count  = m_count + 16'd1;
    prev_e   = e;
    if (setb)     m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
  endtask

  // Timeout is active in cycle tcyc; LOST must become visible one cycle later.
  task automatic check_timeout(input int tcyc);
    wait_until(tcyc);
    check("pre_loss.lost",  16'(lost),  16'h0);
    check("pre_loss.state", 16'(state), 16'(m_state));
    wait_until(tcyc + 1);
    m_state = 3;
    m_sticky = 1'b1;
    check_all("loss");
  endtask

  // Toggle hb_in clks cycles after the previous toggle, then check the result.
  task automatic gap(input int clks, input bit clr_at_edge = 1'b0);
    int d;
    int e;
    int tcyc;
    d = last_d + clks;
    e = d + SYNC;
    tcyc = P * (ticks_before(prev_e + 1) + TOUT);
    if (tcyc < e) check_timeout(tcyc);
    wait_until(d);
    hb_in = ~hb_in;
    last_d = d;
    if (clr_at_edge) begin
      wait_until(e - 1);
      clr_err = 1'b1;
      wait_until(e);
      clr_err = 1'b0;
    end
    model_edge(e, clr_at_edge);
    wait_until(e + 1);
    check_all("edge");
    wait_until(e + 2);
    m_perr = 1'b0;
    check("perr_pulse", 16'(period_err), 16'h0);
  endtask

  // Gap that measures exactly n ticks. It keeps the current edge phase.
  task automatic gap_ticks(input int n);
    if ((prev_e % P) == P - 1) gap(P * (n + 1));
    else                       gap(P * n);
  endtask

  // Gap of about n ticks, chosen so that the edge lands in a tick cycle.
  task automatic gap_on_tick(input int n);
    int base;
    int adj;
    base = last_d + P * n + SYNC;
    adj  = ((P - 1) - (base % P) + P) % P;
    gap(P * n + adj);
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_sticky = 1'b0;
    check("clr_err", 16'(err_sticky), 16'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Lock: 128-tick intervals, locked after the fifth edge.
    for (int i = 0; i < 5; i++) gap(P * 128);
    check("lock.state", 16'(state), 16'h2);

    // Loss while locked, then recovery into ACQUIRE.
    gap(1200);
    for (int i = 0; i < 4; i++) gap(P * 128);

    // Short interval while locked, then clear and relock.
    gap(P * 80);
    check("perr.period", period, 16'd80);
    clr_pulse();
    for (int i = 0; i < 4; i++) gap(P * 128);

    // A clear in the same cycle as a new error: the error wins.
    gap(P * 80, 1'b1);
    clr_pulse();

    // Range boundaries.
    gap_ticks(95);
    gap_ticks(96);
    gap_ticks(160);
    gap_ticks(95);
    gap_ticks(161);
    gap_ticks(96);
    gap_ticks(160);
    gap_ticks(96);
    gap_ticks(160);
    check("bnd.state", 16'(state), 16'h2);

    // Edge on a tick cycle: the next 512-clock gap loses that tick.
    gap_on_tick(128);
    gap(P * 128);
    check("dropped_tick", period, 16'd127);

    // Asynchronous reset while locked, checked before the next clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    hb_in = 1'b0;
    clr_err = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("post_rst");

    // Dead from reset: loss at tick 256, then the first edge.
    gap(1200);

    // Randomised gaps, with occasional clears.
    for (int i = 0; i < 40; i++) begin
      int clks;
      bit clr;
      clks = int'($urandom_range(700, 340));
      clr  = ($urandom_range(7, 0) == 0);
      gap(clks, clr);
      if ($urandom_range(9, 0) == 0) clr_pulse();
    end

    // edge_count wrap.
    @(negedge clk);
    force dut.edge_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.edge_count_reg;
    m_count = 16'hFFFF;
    check("wrap_pre", edge_count, 16'hFFFF);
    gap(P * 128);
    check("wrap", edge_count, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
